// File: rtl/io_out_buffer.sv
// Output write buffer: captures processor out_en writes as {addr, data} in a circular FIFO and
// drains them through a valid/ready handshake. Define IO_OUT_BUFFER_LEVEL_EN for level/almost_full.
module io_out_buffer #(
  parameter int unsigned NUBITS = 16,
  parameter int unsigned NUIOOU = 2,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned AW    = (NUIOOU > 1) ? $clog2(NUIOOU) : 1,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_en,
  input  logic [AW-1:0]     addr_out,
  input  logic [NUBITS-1:0] io_out,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [AW-1:0]     o_addr,
  output logic [NUBITS-1:0] o_data,
  output logic              full,
  output logic              ovf,
  input  logic              clr_ovf
`ifdef IO_OUT_BUFFER_LEVEL_EN
  ,
  output logic [CW-1:0]     level,
  output logic              almost_full
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = AW + NUBITS;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
  localparam logic [CW-1:0] AlmostCnt = CW'(DEPTH - 1);

  logic [EW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_valid, r_full, r_ovf;
  logic [AW-1:0]     r_addr;
  logic [NUBITS-1:0] r_data;

  logic              w_pop, w_push, w_drop, w_bypass;
  logic [PW-1:0]     w_rd_ptr_d;
  logic [CW-1:0]     w_count_d;
  logic [EW-1:0]     w_head_d;

  always_comb begin
    w_pop      = r_valid & o_ready;
    w_push     = out_en & (~r_full | w_pop);
    w_drop     = out_en & r_full & ~w_pop;
    w_rd_ptr_d = r_rd_ptr + PW'(w_pop);
    w_count_d  = r_count + CW'(w_push) - CW'(w_pop);
    // Nothing left in storage after this edge's pop: the new head is the incoming write.
    w_bypass   = (r_count == CW'(w_pop));
    w_head_d   = w_bypass ? {addr_out, io_out} : r_mem[w_rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {addr_out, io_out};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_push);
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
      r_valid  <= (w_count_d != '0);
      r_full   <= (w_count_d == FullCnt);
      r_ovf    <= w_drop | (r_ovf & ~clr_ovf);
      {r_addr, r_data} <= w_head_d;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign full    = r_full;
  assign ovf     = r_ovf;

`ifdef IO_OUT_BUFFER_LEVEL_EN
  logic r_almost_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_count_d >= AlmostCnt);
    end
  end

  assign level       = r_count;
  assign almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_io_out_buffer.sv
// Self-checking bench for io_out_buffer: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_io_out_buffer;

  localparam int unsigned Depth = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        out_en = 1'b0;
  logic [0:0]  addr_out = '0;
  logic [15:0] io_out = '0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [0:0]  o_addr;
  logic [15:0] o_data;
  logic        full;
  logic        ovf;
  logic        clr_ovf = 1'b0;
`ifdef IO_OUT_BUFFER_LEVEL_EN
  logic [3:0]  level;
  logic        almost_full;
`endif

  io_out_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .out_en     (out_en),
    .addr_out   (addr_out),
    .io_out     (io_out),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_addr     (o_addr),
    .o_data     (o_data),
    .full       (full),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf)
`ifdef IO_OUT_BUFFER_LEVEL_EN
    ,
    .level      (level),
    .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;

  // Reference model: FIFO contents as {addr, data} plus the sticky overflow flag.
  logic [16:0] q[$];
  bit          m_ovf = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    check_eq("valid", {31'd0, o_valid}, {31'd0, q.size() != 0});
    check_eq("full", {31'd0, full}, {31'd0, q.size() == Depth});
    check_eq("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    if (q.size() != 0) begin
      logic [16:0] head;
      head = q[0];
      check_eq("addr", {31'd0, o_addr}, {31'd0, head[16]});
      check_eq("data", {16'd0, o_data}, {16'd0, head[15:0]});
    end
  endtask

  // Drive one cycle from a negedge, update the model at the posedge, check at the next negedge.
  task automatic cycle(input bit r, input bit en, input bit a, input logic [15:0] d,
                       input bit rdy, input bit clr);
    bit pop, push, was_full;
    rst = r; out_en = en; addr_out = a; io_out = d; o_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      was_full = (q.size() == Depth);
      pop  = (q.size() != 0) && rdy;
      push = en && (!was_full || pop);
      m_ovf = (en && was_full && !pop) || (m_ovf && !clr);
      if (pop) void'(q.pop_front());
      if (push) q.push_back({a, d});
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, rdy, 1'b0);
  endtask

  task automatic fill(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b1, i[0], base + 16'(i), 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] last;
    int sent, rec;

    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check_eq("rst_addr", {31'd0, o_addr}, 32'd0);
    check_eq("rst_data", {16'd0, o_data}, 32'd0);
    check_eq("rst_valid", {31'd0, o_valid}, 32'd0);

    // Single write, 1-cycle latency.
    cycle(1'b0, 1'b1, 1'b1, 16'h00A5, 1'b1, 1'b0);
    check_eq("single_valid", {31'd0, o_valid}, 32'd1);
    check_eq("single_addr", {31'd0, o_addr}, 32'd1);
    check_eq("single_data", {16'd0, o_data}, 32'h00A5);
    idle(1'b1);
    check_eq("single_gone", {31'd0, o_valid}, 32'd0);

    // Burst with stall, then drain.
    fill(8, 16'd1);
    check_eq("burst_full", {31'd0, full}, 32'd1);
    idle(1'b0);
    idle(1'b0);
    check_eq("burst_hold", {16'd0, o_data}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      check_eq("burst_order", {16'd0, o_data}, 32'(i + 1));
      idle(1'b1);
    end
    check_eq("burst_empty", {31'd0, o_valid}, 32'd0);
    check_eq("burst_nfull", {31'd0, full}, 32'd0);

    // Overflow: dropped write, sticky flag, clear.
    fill(8, 16'h0010);
    cycle(1'b0, 1'b1, 1'b0, 16'h0BAD, 1'b0, 1'b0);
    check_eq("ovf_set", {31'd0, ovf}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      check_eq("ovf_drain", {16'd0, o_data}, 32'(16'h0010 + i));
      idle(1'b1);
    end
    check_eq("ovf_dropped", {31'd0, o_valid}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    check_eq("ovf_clr", {31'd0, ovf}, 32'd0);

    // Full with simultaneous push and pop.
    fill(8, 16'h0020);
    cycle(1'b0, 1'b1, 1'b1, 16'h0077, 1'b1, 1'b0);
    check_eq("pp_ovf", {31'd0, ovf}, 32'd0);
    check_eq("pp_full", {31'd0, full}, 32'd1);
    last = '0;
    for (int i = 0; i < 12; i++) begin
      if (o_valid) last = o_data;
      idle(1'b1);
    end
    check_eq("pp_last", {16'd0, last}, 32'h0077);

    // Wrap-around with at most 3 queued.
    sent = 0;
    rec = 0;
    for (int i = 0; i < 300 && (sent < 20 || q.size() != 0); i++) begin
      bit en, rdy;
      rdy = 1'($urandom_range(0, 1));
      en  = (sent < 20) && (q.size() - ((o_valid && rdy) ? 1 : 0) < 3) && ($urandom_range(0, 1) == 1);
      if (o_valid && rdy) rec++;
      cycle(1'b0, en, 1'($urandom), 16'h0100 + 16'(sent), rdy, 1'b0);
      if (en) sent++;
    end
    check_eq("wrap_rec", 32'(rec), 32'd20);

    // Reset mid-operation.
    fill(5, 16'h0030);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check_eq("mrst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("mrst_full", {31'd0, full}, 32'd0);
    check_eq("mrst_ovf", {31'd0, ovf}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0042, 1'b0, 1'b0);
    check_eq("mrst_data", {16'd0, o_data}, 32'h0042);
    idle(1'b1);
    check_eq("mrst_sole", {31'd0, o_valid}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) != 0), 1'($urandom),
            16'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
